// File: rtl/fight_pkg.sv
// Shared action codes, widths and FSM state type for the fighting-game bots.
package fight_pkg;

    localparam int PLACE_W = 2;
    localparam int LIVES_W = 2;

    localparam logic [2:0] ACT_NONE   = 3'b000;
    localparam logic [2:0] ACT_LEFT   = 3'b001;
    localparam logic [2:0] ACT_RIGHT  = 3'b010;
    localparam logic [2:0] ACT_PUNCH  = 3'b011;
    localparam logic [2:0] ACT_KICK   = 3'b100;
    localparam logic [2:0] ACT_DEFEND = 3'b101;

    typedef enum logic [2:0] {
        THINK,
        DECIDE,
        ISSUE,
        HOLD,
        OVER
    } bot_state_t;

    function automatic logic [PLACE_W-1:0] place_dist(input logic [PLACE_W-1:0] a,
                                                      input logic [PLACE_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/fight_lfsr8.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1); a zero seed is forced to 8'h01 so it never locks up.
module fight_lfsr8 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_seed,
    output logic [7:0] o_q
);
    logic [7:0] w_seed;
    logic [7:0] r_q;

    assign w_seed = (i_seed == 8'h00) ? 8'h01 : i_seed;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= w_seed;
        end else begin
            r_q <= {1'b0, r_q[7:1]} ^ (r_q[0] ? 8'hB8 : 8'h00);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fight_bot_controller.sv
// Computer opponent: paces decisions with a think counter and issues one
// registered action with a single-cycle control strobe that gates the game core.
module fight_bot_controller
    import fight_pkg::*;
#(
    parameter int unsigned THINK_CYCLES  = 4,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5,
    parameter int unsigned ATTACK_WEIGHT = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic [PLACE_W-1:0] i_my_place,
    input  logic [PLACE_W-1:0] i_opp_place,
    input  logic [LIVES_W-1:0] i_my_lives,
    input  logic [LIVES_W-1:0] i_opp_lives,
    output logic [2:0]         o_action,
    output logic               o_control,
    output logic               o_game_over,
    output logic               o_busy
);
    localparam logic [7:0] THINK_LAST = 8'(THINK_CYCLES - 1);
    localparam logic [2:0] ATK_W      = 3'(ATTACK_WEIGHT);

    bot_state_t         r_state;
    bot_state_t         w_next_state;
    logic [7:0]         r_think_cnt;
    logic [7:0]         w_next_cnt;
    logic [2:0]         r_action;
    logic [2:0]         w_next_action;
    logic [2:0]         w_decision;
    logic               r_control;
    logic [7:0]         w_lfsr;
    logic               w_lfsr_unused;
    logic               w_lives_out;
    logic [PLACE_W-1:0] w_dist;

    fight_lfsr8 u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_seed  (LFSR_SEED),
        .o_q     (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[7:4];
    assign w_lives_out   = (i_my_lives == '0) || (i_opp_lives == '0);
    assign w_dist        = place_dist(i_my_place, i_opp_place);

    always_comb begin
        w_decision = ACT_PUNCH;
        if (w_dist >= 2'd2) begin
            w_decision = (i_opp_place > i_my_place) ? ACT_RIGHT : ACT_LEFT;
        end else if (w_dist == 2'd1) begin
            if ((i_my_lives < i_opp_lives) && w_lfsr[2]) begin
                w_decision = ACT_DEFEND;
            end else if ({1'b0, w_lfsr[1:0]} < ATK_W) begin
                w_decision = w_lfsr[3] ? ACT_KICK : ACT_PUNCH;
            end else begin
                w_decision = ACT_DEFEND;
            end
        end
    end

    // Action is registered one state behind so it is stable a full cycle around the strobe.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_think_cnt;
        w_next_action = ACT_NONE;
        case (r_state)
            THINK: begin
                if (i_enable) begin
                    if (r_think_cnt == THINK_LAST) begin
                        w_next_state = DECIDE;
                        w_next_cnt   = 8'd0;
                    end else begin
                        w_next_cnt = r_think_cnt + 8'd1;
                    end
                end
            end
            DECIDE: begin
                w_next_state  = ISSUE;
                w_next_action = w_decision;
            end
            ISSUE: begin
                w_next_state  = HOLD;
                w_next_action = r_action;
            end
            HOLD: begin
                w_next_state  = THINK;
                w_next_action = r_action;
            end
            OVER: begin
                w_next_state = OVER;
            end
            default: begin
                w_next_state = THINK;
            end
        endcase
        if (w_lives_out) begin
            w_next_state = OVER;
            w_next_cnt   = 8'd0;
            if (r_state == DECIDE) begin
                w_next_action = ACT_NONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= THINK;
            r_think_cnt <= 8'd0;
            r_action    <= ACT_NONE;
            r_control   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_think_cnt <= w_next_cnt;
            r_action    <= w_next_action;
            r_control   <= (r_state == ISSUE);
        end
    end

    assign o_action    = r_action;
    assign o_control   = r_control;
    assign o_game_over = (r_state == OVER);
    assign o_busy      = (r_state == DECIDE) || (r_state == ISSUE) || (r_state == HOLD);

endmodule

// File: tb/tb_fight_bot_controller.sv
// Self-checking bench for fight_bot_controller: expected strobe actions are queued
// when inputs are driven and compared when the bot raises control.
`timescale 1ns/1ps
module tb_fight_bot_controller;
    import fight_pkg::*;

    logic       clk      = 1'b0;
    logic       rstN     = 1'b0;
    logic       enable   = 1'b0;
    logic [1:0] myPlace  = 2'd0;
    logic [1:0] oppPlace = 2'd0;
    logic [1:0] myLives  = 2'd3;
    logic [1:0] oppLives = 2'd3;

    logic [2:0] action, atkAction, defAction;
    logic       control, gameOver, busy;
    logic       atkControl, atkGameOver, atkBusy;
    logic       defControl, defGameOver, defBusy;
    logic [7:0] lfsrQ, lfsrZeroQ;
    logic [7:0] lfsrModel = 8'hA5;

    int compareCount    = 0;
    int failCount       = 0;
    int strobeCount     = 0;
    int cyc             = 0;
    int lastStrobeCycle = -1;
    int savedCycle      = 0;
    int savedStrobes    = 0;
    logic [2:0] expQ[$];

    fight_bot_controller dut (
        .i_clk(clk), .i_rst_n(rstN), .i_enable(enable),
        .i_my_place(myPlace), .i_opp_place(oppPlace),
        .i_my_lives(myLives), .i_opp_lives(oppLives),
        .o_action(action), .o_control(control), .o_game_over(gameOver), .o_busy(busy)
    );

    fight_bot_controller #(.ATTACK_WEIGHT(4)) dutAtk (
        .i_clk(clk), .i_rst_n(rstN), .i_enable(enable),
        .i_my_place(2'd1), .i_opp_place(2'd2),
        .i_my_lives(myLives), .i_opp_lives(oppLives),
        .o_action(atkAction), .o_control(atkControl), .o_game_over(atkGameOver), .o_busy(atkBusy)
    );

    fight_bot_controller #(.ATTACK_WEIGHT(0)) dutDef (
        .i_clk(clk), .i_rst_n(rstN), .i_enable(enable),
        .i_my_place(2'd2), .i_opp_place(2'd1),
        .i_my_lives(myLives), .i_opp_lives(oppLives),
        .o_action(defAction), .o_control(defControl), .o_game_over(defGameOver), .o_busy(defBusy)
    );

    fight_lfsr8 lfsrSeeded (.i_clk(clk), .i_rst_n(rstN), .i_seed(8'hA5), .o_q(lfsrQ));
    fight_lfsr8 lfsrZero   (.i_clk(clk), .i_rst_n(rstN), .i_seed(8'h00), .o_q(lfsrZeroQ));

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] mp, input logic [1:0] op,
                                 input logic [1:0] ml, input logic [1:0] ol);
        enable   = en;
        myPlace  = mp;
        oppPlace = op;
        myLives  = ml;
        oppLives = ol;
    endtask

    task automatic waitStrobes(input int n);
        int target = strobeCount + n;
        int budget = n * 40;
        while (strobeCount < target && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        checkOutput("strobeTimeout", 32'(strobeCount >= target), 32'd1);
    endtask

    // Scoreboard: every strobe of the main bot must match the next queued action.
    always @(negedge clk) begin
        if (rstN && control) begin
            strobeCount++;
            lastStrobeCycle = cyc;
            if (expQ.size() > 0) checkOutput("strobeAction", 32'(action), 32'(expQ.pop_front()));
            else                 checkOutput("spuriousStrobe", 32'(control), 32'd0);
        end
        if (rstN && atkControl)
            checkOutput("atkOnlyAttacks", 32'((atkAction == ACT_PUNCH) || (atkAction == ACT_KICK)), 32'd1);
        if (rstN && defControl)
            checkOutput("defOnlyDefends", 32'(defAction), 32'(ACT_DEFEND));
    end

    initial begin
        applyStimulus(1'b1, 2'd0, 2'd3, 2'd3, 2'd3);
        expQ.push_back(ACT_RIGHT);
        #12;
        checkOutput("resetAction", 32'(action), 32'(ACT_NONE));
        checkOutput("resetControl", 32'(control), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetGameOver", 32'(gameOver), 32'd0);
        checkOutput("resetLfsrSeed", 32'(lfsrQ), 32'h0A5);
        checkOutput("resetLfsrZeroSeed", 32'(lfsrZeroQ), 32'h001);
        #10;
        rstN = 1'b1;

        // First decision: RIGHT valid cycles 5..7, strobe only at 6, NONE again at 8.
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            #1;
            lfsrModel = {1'b0, lfsrModel[7:1]} ^ (lfsrModel[0] ? 8'hB8 : 8'h00);
            checkOutput("firstAction", 32'(action), (c >= 5 && c <= 7) ? 32'(ACT_RIGHT) : 32'(ACT_NONE));
            checkOutput("firstControl", 32'(control), (c == 6) ? 32'd1 : 32'd0);
            checkOutput("firstBusy", 32'(busy), (c >= 4 && c <= 6) ? 32'd1 : 32'd0);
            checkOutput("lfsrSequence", 32'(lfsrQ), 32'(lfsrModel));
        end

        applyStimulus(1'b1, 2'd3, 2'd1, 2'd3, 2'd3);
        repeat (3) expQ.push_back(ACT_LEFT);
        waitStrobes(3);
        checkOutput("leftPeriod", 32'(lastStrobeCycle), 32'd27);

        applyStimulus(1'b1, 2'd2, 2'd2, 2'd3, 2'd3);
        repeat (2) expQ.push_back(ACT_PUNCH);
        waitStrobes(2);

        applyStimulus(1'b1, 2'd1, 2'd3, 2'd3, 2'd3);
        expQ.push_back(ACT_RIGHT);
        waitStrobes(1);

        // Freeze the think counter at 1 for 20 cycles; the strobe slips by exactly 20.
        savedCycle = lastStrobeCycle;
        expQ.push_back(ACT_RIGHT);
        @(negedge clk);
        @(negedge clk);
        #1;
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            checkOutput("pauseControl", 32'(control), 32'd0);
            checkOutput("pauseBusy", 32'(busy), 32'd0);
        end
        enable = 1'b1;
        waitStrobes(1);
        checkOutput("resumeStrobeCycle", 32'(lastStrobeCycle), 32'(savedCycle + 27));

        expQ.push_back(ACT_RIGHT);
        waitStrobes(1);
        rstN = 1'b0;
        #1;
        checkOutput("midStrobeResetControl", 32'(control), 32'd0);
        checkOutput("midStrobeResetAction", 32'(action), 32'(ACT_NONE));
        checkOutput("midStrobeResetBusy", 32'(busy), 32'd0);
        #20;
        rstN = 1'b1;
        expQ.push_back(ACT_RIGHT);
        waitStrobes(1);
        checkOutput("postResetStrobeCycle", 32'(lastStrobeCycle), 32'd6);

        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("preOverGameOver", 32'(gameOver), 32'd0);
        oppLives = 2'd0;
        @(negedge clk);
        #1;
        checkOutput("overGameOver", 32'(gameOver), 32'd1);
        checkOutput("overBusy", 32'(busy), 32'd0);
        savedStrobes = strobeCount;
        repeat (100) @(negedge clk);
        #1;
        checkOutput("overNoStrobes", 32'(strobeCount), 32'(savedStrobes));
        checkOutput("overAction", 32'(action), 32'(ACT_NONE));
        checkOutput("overControl", 32'(control), 32'd0);
        checkOutput("overGameOverHeld", 32'(gameOver), 32'd1);
        checkOutput("atkGameOver", 32'(atkGameOver), 32'd1);
        checkOutput("defGameOver", 32'(defGameOver), 32'd1);

        rstN = 1'b0;
        #1;
        checkOutput("overResetGameOver", 32'(gameOver), 32'd0);
        oppLives = 2'd3;
        #20;
        rstN = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("afterOverGameOver", 32'(gameOver), 32'd0);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
